// File: rtl/pipe_pkg.sv
// Shared types for the ID->EX elastic stage: FSM state encoding, control
// bundle layout, bubble constant and a saturating counter helper.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

  // Control bits carried from decode to execute, MSB first.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       flag_write;
    logic [1:0] alu_src;
    logic [2:0] alu_op;
  } id_ex_ctrl_t;

  localparam int unsigned ID_EX_CTRL_W = $bits(id_ex_ctrl_t);
  localparam int unsigned PERF_W       = 32;

  // All-zero control word: a bubble that writes nothing and touches no memory.
  localparam id_ex_ctrl_t BUBBLE_CTRL = '0;

  // Add a small increment to a counter, sticking at all-ones instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_add(input logic [PERF_W-1:0] a,
                                                input logic [1:0]        b);
    logic [PERF_W:0] sum;
    sum = {1'b0, a} + {{(PERF_W-1){1'b0}}, b};
    return sum[PERF_W] ? {PERF_W{1'b1}} : sum[PERF_W-1:0];
  endfunction

endpackage

// File: rtl/stage_entry_reg.sv
// One held pipeline entry (control + data payload). Load captures a new
// entry; clear turns the held control into a bubble and leaves data alone.
module stage_entry_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = ID_EX_CTRL_W,
  parameter int unsigned PAY_W  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [PAY_W-1:0]  data_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [PAY_W-1:0]  data_o
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [PAY_W-1:0]  data_q, data_d;

  // Next entry contents: clear wins over load.
  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (clr_i) begin
      ctrl_d = CTRL_W'(BUBBLE_CTRL);
    end else if (load_i) begin
      ctrl_d = ctrl_i;
      data_d = data_i;
    end
  end

  // Entry storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign ctrl_o = ctrl_q;
  assign data_o = data_q;

endmodule

// File: rtl/id_ex_stage_elastic.sv
// Elastic ID->EX pipeline register with a 2-entry skid buffer (MAIN drives
// the outputs, SKID catches the entry that arrives as EX stalls), so stalls
// never reach upstream combinationally. Flush squashes everything held.
// Optional performance counters are built when ID_EX_STAGE_PERF_EN is defined;
// otherwise perf_stall/perf_flush are tied to zero.
module id_ex_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W   = ID_EX_CTRL_W,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned NUM_DATA = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [PERF_W-1:0]          perf_stall,
  output logic [PERF_W-1:0]          perf_flush
);

  localparam int unsigned PAY_W = NUM_DATA * DATA_W;

  stage_state_t state_q, state_d;

  logic              in_fire;
  logic              out_fire;
  logic              main_load;
  logic              main_clr;
  logic              main_from_skid;
  logic              skid_load;
  logic              skid_clr;
  logic [CTRL_W-1:0] main_ctrl_in;
  logic [PAY_W-1:0]  main_data_in;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [PAY_W-1:0]  skid_data;

  // Handshake flags decode straight from the state register.
  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_FULL);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and entry load/clear strobes. MAIN is cleared whenever the
  // stage goes empty so out_ctrl reads as a bubble straight from the register.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d   = ST_BUSY;
            main_load = 1'b1;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            state_d   = ST_FULL;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d        = ST_BUSY;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  // MAIN refills from SKID when draining a full stage, else from upstream.
  always_comb begin
    main_ctrl_in = in_ctrl;
    main_data_in = in_data;
    if (main_from_skid) begin
      main_ctrl_in = skid_ctrl;
      main_data_in = skid_data;
    end
  end

  stage_entry_reg #(
    .CTRL_W (CTRL_W),
    .PAY_W  (PAY_W)
  ) u_main (
    .clk    (clk),
    .rst_n  (reset),
    .load_i (main_load),
    .clr_i  (main_clr),
    .ctrl_i (main_ctrl_in),
    .data_i (main_data_in),
    .ctrl_o (out_ctrl),
    .data_o (out_data)
  );

  stage_entry_reg #(
    .CTRL_W (CTRL_W),
    .PAY_W  (PAY_W)
  ) u_skid (
    .clk    (clk),
    .rst_n  (reset),
    .load_i (skid_load),
    .clr_i  (skid_clr),
    .ctrl_i (in_ctrl),
    .data_i (in_data),
    .ctrl_o (skid_ctrl),
    .data_o (skid_data)
  );

`ifdef ID_EX_STAGE_PERF_EN
  logic [PERF_W-1:0] stall_q, stall_d;
  logic [PERF_W-1:0] flush_q, flush_d;
  logic [1:0]        squashed;

  // Entries lost to a flush: everything held minus one consumed this cycle.
  always_comb begin
    squashed = 2'd0;
    case (state_q)
      ST_BUSY: squashed = 2'd1;
      ST_FULL: squashed = 2'd2;
      default: squashed = 2'd0;
    endcase
    if (out_fire) begin
      squashed = squashed - 2'd1;
    end
    stall_d = sat_add(stall_q, {1'b0, out_valid & ~out_ready});
    flush_d = flush ? sat_add(flush_q, squashed) : flush_q;
  end

  // Saturating performance counters, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign perf_stall = stall_q;
  assign perf_flush = flush_q;
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_elastic.sv
// Bench for id_ex_stage_elastic: a queue model of the 2-deep elastic stage is
// checked every cycle, plus directed scenarios with hand-computed values.
module tb_id_ex_stage_elastic;

  localparam int unsigned CW = 9;
  localparam int unsigned DW = 64;
  localparam int unsigned ND = 4;
  localparam int unsigned PW = DW * ND;
`ifdef ID_EX_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [CW-1:0] c;
    logic [PW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [PW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [PW-1:0] out_data;
  logic [31:0]   perf_stall;
  logic [31:0]   perf_flush;

  int n_cmp = 0;
  int n_err = 0;

  ent_t        mq[$];
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;

  id_ex_stage_elastic #(
    .CTRL_W   (CW),
    .DATA_W   (DW),
    .NUM_DATA (ND)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data),
    .perf_stall (perf_stall),
    .perf_flush (perf_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, PW'(act), PW'(exp));
  endtask

  function automatic logic [PW-1:0] mk(input logic [31:0] k);
    logic [63:0] w;
    w = 64'(k);
    return {64'hCAFE_F00D_0000_0000 | w, ~w, 64'h1234_5678_9ABC_DEF0 ^ w, w};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a FIFO of at most two entries; flush empties it.
  always @(posedge clk or negedge reset) begin : model
    int n;
    bit ofire;
    bit ifire;
    if (!reset) begin
      mq.delete();
      m_stall = '0;
      m_flush = '0;
    end else begin
      n     = mq.size();
      ofire = (n > 0) && out_ready;
      ifire = in_valid && (n < 2);
      if (n > 0 && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (flush) begin
        m_flush = m_flush + 32'(n) - 32'(ofire);
        mq.delete();
      end else begin
        if (ofire) void'(mq.pop_front());
        if (ifire) mq.push_back('{c: in_ctrl, d: in_data});
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    chk1("cmp_out_valid", out_valid, mq.size() > 0);
    chk1("cmp_in_ready", in_ready, mq.size() < 2);
    chk("cmp_out_ctrl", PW'(out_ctrl), (mq.size() > 0) ? PW'(mq[0].c) : PW'(0));
    if (mq.size() > 0) chk("cmp_out_data", out_data, mq[0].d);
    chk("cmp_perf_stall", PW'(perf_stall), PERF ? PW'(m_stall) : PW'(0));
    chk("cmp_perf_flush", PW'(perf_flush), PERF ? PW'(m_flush) : PW'(0));
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : driver
    // Reset held with input offered: nothing may be captured.
    reset = 1'b0; in_valid = 1'b1; in_ctrl = 9'h0F3; in_data = mk(32'h77);
    repeat (3) tick();
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_ctrl", PW'(out_ctrl), PW'(0));
    chk("rst_out_data", out_data, PW'(0));
    chk("rst_perf_stall", PW'(perf_stall), PW'(0));
    reset = 1'b1;
    tick();
    chk1("rel_out_valid", out_valid, 1'b1);
    chk("rel_out_ctrl", PW'(out_ctrl), PW'(9'h0F3));
    chk("rel_da", PW'(out_data[63:0]), PW'(64'h77));
    chk("rel_data", out_data, mk(32'h77));
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk1("rel_drain", out_valid, 1'b0);

    // Streaming: 8 back-to-back entries, one-cycle latency, no bubbles.
    in_ctrl = 9'h1A5;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_data = mk(32'(k));
      tick();
      chk1("stream_valid", out_valid, 1'b1);
      chk("stream_da", PW'(out_data[63:0]), PW'(64'(k)));
      chk("stream_ctrl", PW'(out_ctrl), PW'(9'h1A5));
      chk1("stream_in_ready", in_ready, 1'b1);
    end
    in_valid = 1'b0;
    tick();
    chk1("stream_drain", out_valid, 1'b0);

    // Backpressure: A in MAIN, B in SKID, C held upstream until room appears.
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 9'h101; in_data = mk(32'h11);
    tick();
    chk("bp_a", PW'(out_data[63:0]), PW'(64'h11));
    chk1("bp_ready1", in_ready, 1'b1);
    in_ctrl = 9'h102; in_data = mk(32'h22);
    tick();
    chk1("bp_full_ready", in_ready, 1'b0);
    chk("bp_hold_a", PW'(out_data[63:0]), PW'(64'h11));
    in_ctrl = 9'h103; in_data = mk(32'h33);
    tick();
    chk1("bp_still_full", in_ready, 1'b0);
    chk("bp_ctrl_a", PW'(out_ctrl), PW'(9'h101));
    out_ready = 1'b1;
    tick();
    chk("bp_b", PW'(out_data[63:0]), PW'(64'h22));
    chk("bp_ctrl_b", PW'(out_ctrl), PW'(9'h102));
    chk1("bp_ready_b", in_ready, 1'b1);
    tick();
    chk("bp_c", PW'(out_data[63:0]), PW'(64'h33));
    chk("bp_ctrl_c", PW'(out_ctrl), PW'(9'h103));
    in_valid = 1'b0;
    tick();
    chk1("bp_drain", out_valid, 1'b0);

    // Asynchronous reset in the middle of a cycle while BUSY.
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 9'h0C4; in_data = mk(32'h44);
    tick();
    in_valid = 1'b0;
    chk1("ar_busy", out_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk1("ar_valid_drop", out_valid, 1'b0);
    chk("ar_ctrl", PW'(out_ctrl), PW'(0));
    chk1("ar_in_ready", in_ready, 1'b1);
    tick();
    reset = 1'b1;

    // Stall counting: one entry held for five cycles with EX not ready.
    in_valid = 1'b1; in_ctrl = 9'h0AA; in_data = mk(32'h50);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("stall_5", PW'(perf_stall), PERF ? PW'(32'd5) : PW'(0));
    chk("stall_hold", PW'(out_data[63:0]), PW'(64'h50));

    // Flush in FULL with a valid input: all three disappear.
    in_valid = 1'b1; in_ctrl = 9'h0BB; in_data = mk(32'h61);
    tick();
    chk1("fl_full", in_ready, 1'b0);
    flush = 1'b1; in_ctrl = 9'h1FF; in_data = mk(32'h62);
    tick();
    chk1("fl_out_valid", out_valid, 1'b0);
    chk("fl_out_ctrl", PW'(out_ctrl), PW'(0));
    chk1("fl_in_ready", in_ready, 1'b1);
    chk("fl_perf", PW'(perf_flush), PERF ? PW'(32'd2) : PW'(0));
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("fl_no_ghost", out_valid, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
